// File: rtl/knn_pkg.sv
// knn_pkg: shared FSM states, neighbour entry type and distance helpers for the KNN vote selector
package knn_pkg;

    typedef enum logic [2:0] {IDLE, COLLECT, COUNT, SELECT, DONE} knn_state_t;

    localparam int KNN_W      = 16;
    localparam int KNN_TYPE_W = 2;

    typedef struct packed {
        logic                  valid;
        logic [KNN_W-1:0]      distance;
        logic [KNN_TYPE_W-1:0] data_type;
    } knn_entry_t;

    // Largest distance an empty slot carries: MSB clear, all other bits set.
    function automatic logic [63:0] max_dist(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/knn_vote_selector_if.sv
// knn_vote_selector_if: sample input, control and classification result bundle
interface knn_vote_selector_if
    import knn_pkg::*;
#(
    parameter int W      = KNN_W,
    parameter int TYPE_W = KNN_TYPE_W,
    parameter int CW     = 4
);
    logic              start;
    logic [W-1:0]      distance;
    logic [TYPE_W-1:0] data_type;
    logic              done;
    logic              busy;
    logic [CW-1:0]     sample_count;
    logic [TYPE_W-1:0] class_out;
    logic              class_valid;
    logic [W-1:0]      nearest_distance;

    modport master (
        output start, distance, data_type, done,
        input  busy, sample_count, class_out, class_valid, nearest_distance
    );

    modport slave (
        input  start, distance, data_type, done,
        output busy, sample_count, class_out, class_valid, nearest_distance
    );
endinterface

// File: rtl/knn_sorted_insert.sv
// knn_sorted_insert: K-slot sorted neighbour list with single-cycle parallel compare-and-shift insertion
module knn_sorted_insert
    import knn_pkg::*;
#(
    parameter int W      = KNN_W,
    parameter int TYPE_W = KNN_TYPE_W,
    parameter int K      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          insert_en,
    input  logic [W-1:0]                  in_distance,
    input  logic [TYPE_W-1:0]             in_type,
    output logic [K*(1+W+TYPE_W)-1:0]     list
);
    localparam int EW = 1 + W + TYPE_W;
    localparam logic [W-1:0] MAX_D = W'(max_dist(W));

    logic [K-1:0]      valid_q, valid_d, place;
    logic [W-1:0]      dist_q[K], dist_d[K];
    logic [TYPE_W-1:0] type_q[K], type_d[K];

    // A slot accepts the new entry if it is empty or strictly farther, so equal distances keep arrival order.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            place[i]  = !valid_q[i] || dist_q[i] > in_distance;
            valid_d[i] = valid_q[i];
            dist_d[i]  = dist_q[i];
            type_d[i]  = type_q[i];
        end
        if (clear) begin
            for (int i = 0; i < K; i++) begin
                valid_d[i] = 1'b0;
                dist_d[i]  = MAX_D;
                type_d[i]  = '0;
            end
        end else if (insert_en) begin
            if (place[0]) begin
                valid_d[0] = 1'b1;
                dist_d[0]  = in_distance;
                type_d[0]  = in_type;
            end
            for (int i = 1; i < K; i++) begin
                if (place[i-1]) begin
                    valid_d[i] = valid_q[i-1];
                    dist_d[i]  = dist_q[i-1];
                    type_d[i]  = type_q[i-1];
                end else if (place[i]) begin
                    valid_d[i] = 1'b1;
                    dist_d[i]  = in_distance;
                    type_d[i]  = in_type;
                end
            end
        end
    end

    // List registers; reset leaves every slot empty at the max distance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= MAX_D;
                type_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            dist_q  <= dist_d;
            type_q  <= type_d;
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_flat
        assign list[g*EW +: EW] = {valid_q[g], dist_q[g], type_q[g]};
    end

endmodule

// File: rtl/knn_vote_selector.sv
// knn_vote_selector: keeps the K nearest samples and majority-votes a class; KNN_TIE_NEAREST_EN breaks vote ties by nearest neighbour
module knn_vote_selector
    import knn_pkg::*;
#(
    parameter int W            = KNN_W,
    parameter int TYPE_W       = KNN_TYPE_W,
    parameter int K            = 3,
    parameter int NUM_TRAINING = 8,
    parameter int NUM_TYPES    = 4
) (
    input logic                clk,
    input logic                rst,
    knn_vote_selector_if.slave bus
);
    localparam int EW = 1 + W + TYPE_W;
    localparam int CW = $clog2(NUM_TRAINING + 1);
    localparam int VW = $clog2(K + 1);
    localparam logic [CW-1:0]     N_LAST = CW'(NUM_TRAINING);
    localparam logic [VW-1:0]     K_LAST = VW'(K - 1);
    localparam logic [VW-1:0]     NO_RANK = VW'(K);
    localparam logic [TYPE_W-1:0] T_LAST = TYPE_W'(NUM_TYPES - 1);
    localparam logic [W-1:0]      MAX_D  = W'(max_dist(W));

    knn_state_t        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [VW-1:0]     slot_q, slot_d;
    logic [TYPE_W-1:0] cls_q, cls_d, best_q, best_d, class_q, class_d;
    logic [VW-1:0]     votes_q[NUM_TYPES], votes_d[NUM_TYPES];
    logic [VW-1:0]     best_votes_q, best_votes_d;
    logic              valid_q, valid_d;
    logic [W-1:0]      near_q, near_d;
    logic              insert_en, clear, win;
    logic [K*EW-1:0]   list;
    logic              lv[K];
    logic [TYPE_W-1:0] lt[K];
`ifdef KNN_TIE_NEAREST_EN
    logic [VW-1:0]     rank_q[NUM_TYPES], rank_d[NUM_TYPES];
    logic [VW-1:0]     best_rank_q, best_rank_d;
`endif

    knn_sorted_insert #(.W(W), .TYPE_W(TYPE_W), .K(K)) u_list (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .insert_en  (insert_en),
        .in_distance(bus.distance),
        .in_type    (bus.data_type),
        .list       (list)
    );

    for (genvar g = 0; g < K; g++) begin : g_slot
        assign lv[g] = list[g*EW + EW - 1];
        assign lt[g] = list[g*EW +: TYPE_W];
    end

    // Next-state and datapath: collect samples, count votes per slot, pick the winner, publish it.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        slot_d       = slot_q;
        cls_d        = cls_q;
        best_d       = best_q;
        best_votes_d = best_votes_q;
        votes_d      = votes_q;
        class_d      = class_q;
        near_d       = near_q;
        valid_d      = 1'b0;
        insert_en    = 1'b0;
        clear        = 1'b0;
        win          = votes_q[cls_q] > best_votes_q;
`ifdef KNN_TIE_NEAREST_EN
        rank_d       = rank_q;
        best_rank_d  = best_rank_q;
        win          = win || (votes_q[cls_q] == best_votes_q && rank_q[cls_q] < best_rank_q);
`endif
        if (bus.start) begin
            state_d = COLLECT;
            count_d = '0;
            clear   = 1'b1;
            votes_d = '{default: '0};
`ifdef KNN_TIE_NEAREST_EN
            rank_d  = '{default: NO_RANK};
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (count_q == N_LAST) begin
                        state_d = COUNT;
                        slot_d  = '0;
                    end else if (bus.done) begin
                        insert_en = 1'b1;
                        count_d   = count_q + CW'(1);
                    end
                end
                COUNT: begin
                    if (lv[slot_q] && 32'(lt[slot_q]) < NUM_TYPES) begin
                        votes_d[lt[slot_q]] = votes_q[lt[slot_q]] + VW'(1);
`ifdef KNN_TIE_NEAREST_EN
                        if (rank_q[lt[slot_q]] == NO_RANK) rank_d[lt[slot_q]] = slot_q;
`endif
                    end
                    slot_d = slot_q + VW'(1);
                    if (slot_q == K_LAST) begin
                        state_d      = SELECT;
                        cls_d        = '0;
                        best_d       = '0;
                        best_votes_d = '0;
`ifdef KNN_TIE_NEAREST_EN
                        best_rank_d  = NO_RANK;
`endif
                    end
                end
                SELECT: begin
                    if (win) begin
                        best_d       = cls_q;
                        best_votes_d = votes_q[cls_q];
`ifdef KNN_TIE_NEAREST_EN
                        best_rank_d  = rank_q[cls_q];
`endif
                    end
                    cls_d = cls_q + TYPE_W'(1);
                    if (cls_q == T_LAST) state_d = DONE;
                end
                DONE: begin
                    class_d = best_q;
                    near_d  = list[TYPE_W +: W];
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters, votes and result registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            slot_q       <= '0;
            cls_q        <= '0;
            best_q       <= '0;
            best_votes_q <= '0;
            votes_q      <= '{default: '0};
            class_q      <= '0;
            near_q       <= MAX_D;
            valid_q      <= 1'b0;
`ifdef KNN_TIE_NEAREST_EN
            rank_q       <= '{default: NO_RANK};
            best_rank_q  <= NO_RANK;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            slot_q       <= slot_d;
            cls_q        <= cls_d;
            best_q       <= best_d;
            best_votes_q <= best_votes_d;
            votes_q      <= votes_d;
            class_q      <= class_d;
            near_q       <= near_d;
            valid_q      <= valid_d;
`ifdef KNN_TIE_NEAREST_EN
            rank_q       <= rank_d;
            best_rank_q  <= best_rank_d;
`endif
        end
    end

    assign bus.busy             = state_q != IDLE;
    assign bus.sample_count     = count_q;
    assign bus.class_out        = class_q;
    assign bus.class_valid      = valid_q;
    assign bus.nearest_distance = near_q;

endmodule

// File: tb/tb_knn_vote_selector.sv
// tb_knn_vote_selector: directed checks of sorting, voting, abort, ignored strobes and async reset
module tb_knn_vote_selector;
    import knn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   lat;
    knn_entry_t e;

    always #5 clk = ~clk;

    knn_vote_selector_if #(.W(16), .TYPE_W(2), .CW(3)) bus ();

    knn_vote_selector #(.W(16), .TYPE_W(2), .K(3), .NUM_TRAINING(5), .NUM_TYPES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] t);
        bus.done      = 1'b1;
        bus.distance  = d;
        bus.data_type = t;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = -1;
        for (int i = 1; i <= 30 && n < 0; i++) begin
            tick();
            if (bus.class_valid) n = i;
        end
    endtask

    task automatic run_basic(input string tag);
        pulse_start();
        send(40, 1); send(10, 2); send(30, 2); send(20, 1); send(50, 3);
        check({tag, "_count"}, bus.sample_count, 5);
        wait_result(lat);
        check({tag, "_latency"}, lat, 9);
        check({tag, "_class"}, bus.class_out, 2);
        check({tag, "_nearest"}, bus.nearest_distance, 10);
        check({tag, "_busy_low"}, bus.busy, 0);
        tick();
        check({tag, "_valid_one_cycle"}, bus.class_valid, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.done = 1'b0;
        bus.distance = '0;
        bus.data_type = '0;
        repeat (2) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.sample_count, 0);
        check("rst_class", bus.class_out, 0);
        check("rst_valid", bus.class_valid, 0);
        check("rst_nearest", bus.nearest_distance, 16'h7fff);
        rst = 1'b1;
        tick();

        run_basic("basic");

        pulse_start();
        check("tie_busy", bus.busy, 1);
        send(5, 3); send(5, 0); send(5, 0); send(9, 1); send(9, 1);
        for (int i = 0; i < 3; i++) begin
            e = dut.u_list.list[i*19 +: 19];
            check($sformatf("tie_slot%0d", i), e, (i == 0) ? {1'b1, 16'd5, 2'd3} : {1'b1, 16'd5, 2'd0});
        end
        wait_result(lat);
        check("tie_latency", lat, 9);
        check("tie_class", bus.class_out, 0);

        pulse_start();
        send(7, 1); send(3, 2); send(8, 3); send(100, 0); send(100, 0);
        wait_result(lat);
`ifdef KNN_TIE_NEAREST_EN
        check("vote_tie_class", bus.class_out, 2);
`else
        check("vote_tie_class", bus.class_out, 1);
`endif
        check("vote_tie_nearest", bus.nearest_distance, 3);

        pulse_start();
        send(1, 1); send(1, 1); send(1, 1);
        check("abort_count_mid", bus.sample_count, 3);
        bus.done = 1'b1;
        bus.distance = 0;
        bus.data_type = 1;
        pulse_start();
        bus.done = 1'b0;
        check("abort_count_zero", bus.sample_count, 0);
        send(1, 3); send(2, 3); send(3, 0); send(4, 0); send(6, 0);
        wait_result(lat);
        check("abort_latency", lat, 9);
        check("abort_class", bus.class_out, 3);
        check("abort_nearest", bus.nearest_distance, 1);

        send(0, 1);
        check("idle_done_count", bus.sample_count, 5);
        check("idle_done_busy", bus.busy, 0);
        pulse_start();
        send(40, 1); send(10, 2); send(30, 2); send(20, 1); send(50, 3);
        bus.done = 1'b1;
        bus.distance = 0;
        bus.data_type = 3;
        repeat (2) tick();
        bus.done = 1'b0;
        check("count_done_count", bus.sample_count, 5);
        wait_result(lat);
        check("count_done_latency", lat, 7);
        check("count_done_class", bus.class_out, 2);
        check("count_done_nearest", bus.nearest_distance, 10);

        pulse_start();
        send(40, 1); send(10, 2); send(30, 2); send(20, 1); send(50, 3);
        repeat (5) tick();
        check("select_busy", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        check("async_busy", bus.busy, 0);
        check("async_valid", bus.class_valid, 0);
        check("async_class", bus.class_out, 0);
        check("async_count", bus.sample_count, 0);
        check("async_nearest", bus.nearest_distance, 16'h7fff);
        tick();
        rst = 1'b1;
        tick();
        run_basic("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
